// File: rtl/phase_sequencer.sv
// phase_sequencer: frame controller that runs up to NUM_PHASES engines in
// ascending index order per frame via an enable/done handshake, with a
// per-frame phase mask, optional frame-tick pacing, a per-phase watchdog and
// sticky overrun/timeout status.
module phase_sequencer #(
  parameter int NUM_PHASES  = 2,
  parameter int IDX_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  parameter bit FRAME_PACED = 1'b0,
  parameter int TIMEOUT_W   = 20,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_PHASES-1:0] phase_mask,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic                  frame_tick,
  input  logic                  pause,
  input  logic                  clear_err,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [IDX_W-1:0]      cur_phase,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_count,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      timeout_phase,
  output logic                  overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [NUM_PHASES-1:0] ONE      = NUM_PHASES'(1);
  localparam logic [TIMEOUT_W-1:0]  TMO_LAST =
    TIMEOUT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                  state_q, state_d;
  logic [NUM_PHASES-1:0]   mask_q, mask_d;
  logic [TIMEOUT_W-1:0]    timer_q, timer_d;
  logic [NUM_PHASES-1:0]   phase_en_q, phase_en_d;
  logic [IDX_W-1:0]        cur_phase_q, cur_phase_d;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_done_q, frame_done_d;
  logic [CNT_W-1:0]        frame_count_q, frame_count_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]        timeout_phase_q, timeout_phase_d;
  logic                    overrun_q, overrun_d;

  logic                    start_ok;
  logic                    cur_done;
  logic                    wd_hit;
  logic                    advance;
  logic                    nxt_found;
  logic [IDX_W-1:0]        nxt_idx;
  logic [IDX_W-1:0]        first_idx;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_PHASES-1:0] m);
    lowest_set = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (m[i]) lowest_set = IDX_W'(i);
  endfunction

  // Next enabled phase above the active one in the frame's snapshot mask.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_phase_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(i);
      end
    end
  end

  // Handshake qualifiers: only the active engine's done bit counts, and the
  // watchdog forces completion on the last allowed cycle of a phase.
  always_comb begin
    first_idx = lowest_set(phase_mask);
    start_ok  = !pause && (|phase_mask) && (!FRAME_PACED || frame_tick);
    cur_done  = (state_q == RUN) && (|(phase_done & phase_en_q));
    wd_hit    = (TIMEOUT_CYC > 0) && (state_q == RUN) && !cur_done &&
                (timer_q == TMO_LAST);
    advance   = cur_done || wd_hit;
  end

  // Next-state and registered-output computation for the frame FSM.
  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    timer_d         = timer_q;
    phase_en_d      = phase_en_q;
    cur_phase_d     = cur_phase_q;
    frame_start_d   = 1'b0;
    frame_done_d    = 1'b0;
    frame_count_d   = frame_count_q;
    timeout_err_d   = timeout_err_q;
    timeout_phase_d = timeout_phase_q;
    overrun_d       = overrun_q;

    // Clear first so a same-cycle set below takes priority.
    if (clear_err) begin
      timeout_err_d = 1'b0;
      overrun_d     = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          mask_d        = phase_mask;
          cur_phase_d   = first_idx;
          phase_en_d    = ONE << first_idx;
          frame_start_d = 1'b1;
          timer_d       = '0;
          state_d       = RUN;
        end
      end
      RUN: begin
        timer_d = timer_q + TIMEOUT_W'(1);
        // Ticks are never queued; one arriving mid-frame (including the
        // cycle that ends the frame) is only reported.
        if (FRAME_PACED && frame_tick) overrun_d = 1'b1;
        if (wd_hit) begin
          timeout_err_d   = 1'b1;
          timeout_phase_d = cur_phase_q;
        end
        if (advance) begin
          timer_d = '0;
          if (nxt_found) begin
            cur_phase_d = nxt_idx;
            phase_en_d  = ONE << nxt_idx;
          end else begin
            phase_en_d    = '0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + CNT_W'(1);
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops everything back to IDLE at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      mask_q          <= '0;
      timer_q         <= '0;
      phase_en_q      <= '0;
      cur_phase_q     <= '0;
      frame_start_q   <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_count_q   <= '0;
      timeout_err_q   <= 1'b0;
      timeout_phase_q <= '0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      timer_q         <= timer_d;
      phase_en_q      <= phase_en_d;
      cur_phase_q     <= cur_phase_d;
      frame_start_q   <= frame_start_d;
      frame_done_q    <= frame_done_d;
      frame_count_q   <= frame_count_d;
      timeout_err_q   <= timeout_err_d;
      timeout_phase_q <= timeout_phase_d;
      overrun_q       <= overrun_d;
    end
  end

  assign phase_en      = phase_en_q;
  assign cur_phase     = cur_phase_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
  assign timeout_err   = timeout_err_q;
  assign timeout_phase = timeout_phase_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a cycle table for the two-phase
// unpaced alternation, then hand sequences on a paced 4-phase instance and a
// 3-phase instance with the watchdog enabled.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u2: 2 phases, unpaced, watchdog off
  logic [1:0]  mask2, done2, en2;
  logic        tick2, pause2, clr2, fs2, fd2, te2, ov2;
  logic [0:0]  cur2, tp2;
  logic [15:0] cnt2;

  // u4: 4 phases, paced, watchdog off
  logic [3:0]  mask4, done4, en4;
  logic        tick4, pause4, clr4, fs4, fd4, te4, ov4;
  logic [1:0]  cur4, tp4;
  logic [15:0] cnt4;

  // u3: 3 phases, unpaced, watchdog 8 cycles
  logic [2:0]  mask3, done3, en3;
  logic        tick3, pause3, clr3, fs3, fd3, te3, ov3;
  logic [1:0]  cur3, tp3;
  logic [15:0] cnt3;

  phase_sequencer #(.NUM_PHASES(2), .IDX_W(1), .FRAME_PACED(1'b0),
                    .TIMEOUT_W(20), .TIMEOUT_CYC(0), .CNT_W(16)) u2 (
    .clk(clk), .resetn(resetn), .phase_mask(mask2), .phase_done(done2),
    .frame_tick(tick2), .pause(pause2), .clear_err(clr2), .phase_en(en2),
    .cur_phase(cur2), .frame_start(fs2), .frame_done(fd2), .frame_count(cnt2),
    .timeout_err(te2), .timeout_phase(tp2), .overrun(ov2));

  phase_sequencer #(.NUM_PHASES(4), .IDX_W(2), .FRAME_PACED(1'b1),
                    .TIMEOUT_W(20), .TIMEOUT_CYC(0), .CNT_W(16)) u4 (
    .clk(clk), .resetn(resetn), .phase_mask(mask4), .phase_done(done4),
    .frame_tick(tick4), .pause(pause4), .clear_err(clr4), .phase_en(en4),
    .cur_phase(cur4), .frame_start(fs4), .frame_done(fd4), .frame_count(cnt4),
    .timeout_err(te4), .timeout_phase(tp4), .overrun(ov4));

  phase_sequencer #(.NUM_PHASES(3), .IDX_W(2), .FRAME_PACED(1'b0),
                    .TIMEOUT_W(20), .TIMEOUT_CYC(8), .CNT_W(16)) u3 (
    .clk(clk), .resetn(resetn), .phase_mask(mask3), .phase_done(done3),
    .frame_tick(tick3), .pause(pause3), .clear_err(clr3), .phase_en(en3),
    .cur_phase(cur3), .frame_start(fs3), .frame_done(fd3), .frame_count(cnt3),
    .timeout_err(te3), .timeout_phase(tp3), .overrun(ov3));

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  en;
    logic        cur;
    logic        start;
    logic        fdone;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // row = {done driven this cycle, outputs expected this cycle}
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 16'd1};
    tbl[11] = '{2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[12] = '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[13] = '{2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[14] = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 16'd2};
    tbl[15] = '{2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 16'd2};

    mask2 = '0; done2 = '0; tick2 = 0; pause2 = 0; clr2 = 0;
    mask4 = '0; done4 = '0; tick4 = 0; pause4 = 0; clr4 = 0;
    mask3 = '0; done3 = '0; tick3 = 0; pause3 = 0; clr3 = 0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset_u2", 32'({en2, cur2, fs2, fd2, cnt2, te2, tp2, ov2}), 32'd0);
    chk("reset_u4", 32'({en4, cur4, fs4, fd4, cnt4, te4, tp4, ov4}), 32'd0);

    // ---- two-phase alternation, table driven ----
    resetn = 1'b1;
    mask2  = 2'b11;
    for (int i = 0; i < 16; i++) begin
      done2 = tbl[i].done;
      chk($sformatf("alt_row%0d", i),
          32'({en2, cur2, fs2, fd2, cnt2}),
          32'({tbl[i].en, tbl[i].cur, tbl[i].start, tbl[i].fdone, tbl[i].cnt}));
      step();
    end
    done2 = '0;
    mask2 = '0;

    // ---- paced 4-phase, sparse mask ----
    mask4 = 4'b1010;
    tick4 = 1'b1;
    chk("p4_idle_en", 32'(en4), 32'd0);
    step(); tick4 = 1'b0;
    chk("p4_first", 32'({en4, cur4, fs4}), 32'({4'b0010, 2'd1, 1'b1}));
    done4 = 4'b0010; step(); done4 = '0;
    chk("p4_next", 32'({en4, cur4, fs4}), 32'({4'b1000, 2'd3, 1'b0}));
    done4 = 4'b1000; step(); done4 = '0;
    chk("p4_fdone", 32'({en4, fd4, cnt4}), 32'({4'b0000, 1'b1, 16'd1}));
    repeat (3) step();
    chk("p4_wait_tick", 32'({en4, fs4, cnt4}), 32'({4'b0000, 1'b0, 16'd1}));

    // ---- overrun ----
    tick4 = 1'b1; step(); tick4 = 1'b0;
    tick4 = 1'b1; step(); tick4 = 1'b0;
    chk("ov_set", 32'({ov4, en4}), 32'({1'b1, 4'b0010}));
    done4 = 4'b0010; step();
    done4 = 4'b1000; step(); done4 = '0;
    chk("ov_one_frame", 32'({fd4, cnt4}), 32'({1'b1, 16'd2}));
    repeat (2) step();
    chk("ov_no_extra", 32'({en4, ov4}), 32'({4'b0000, 1'b1}));
    tick4 = 1'b1; step(); tick4 = 1'b0;
    tick4 = 1'b1; clr4 = 1'b1; step(); tick4 = 1'b0; clr4 = 1'b0;
    chk("ov_set_beats_clear", 32'(ov4), 32'd1);
    clr4 = 1'b1; step(); clr4 = 1'b0;
    chk("ov_cleared", 32'({ov4, en4}), 32'({1'b0, 4'b0010}));
    done4 = 4'b0010; step();
    done4 = 4'b1000; tick4 = 1'b1; step(); done4 = '0; tick4 = 1'b0;
    chk("ov_at_return", 32'({fd4, ov4, cnt4}), 32'({1'b1, 1'b1, 16'd3}));
    repeat (2) step();
    chk("ov_return_no_frame", 32'(en4), 32'd0);
    clr4 = 1'b1; step(); clr4 = 1'b0;

    // ---- empty mask: ticks dropped ----
    mask4 = '0;
    for (int k = 0; k < 3; k++) begin
      tick4 = 1'b1; step(); tick4 = 1'b0; step();
      chk($sformatf("mask0_idle%0d", k), 32'({en4, cnt4}), 32'({4'b0000, 16'd3}));
    end

    // ---- pause mid-frame ----
    mask4 = 4'b1010;
    tick4 = 1'b1; step(); tick4 = 1'b0;
    pause4 = 1'b1; step();
    chk("pause_mid_run", 32'(en4), 32'(4'b0010));
    done4 = 4'b0010; step();
    done4 = 4'b1000; step(); done4 = '0;
    chk("pause_frame_done", 32'({fd4, cnt4}), 32'({1'b1, 16'd4}));
    for (int k = 0; k < 3; k++) begin
      tick4 = 1'b1; step(); tick4 = 1'b0;
      chk($sformatf("pause_hold%0d", k), 32'(en4), 32'd0);
    end
    pause4 = 1'b0;
    tick4 = 1'b1; step(); tick4 = 1'b0;
    chk("pause_release", 32'({en4, fs4}), 32'({4'b0010, 1'b1}));

    // ---- watchdog on 3-phase ----
    mask3 = 3'b111;
    step();
    chk("wd_start", 32'({en3, fs3}), 32'({3'b001, 1'b1}));
    repeat (7) step();
    chk("wd_before", 32'({en3, te3}), 32'({3'b001, 1'b0}));
    step();
    chk("wd_fire", 32'({en3, cur3, te3, tp3}), 32'({3'b010, 2'd1, 1'b1, 2'd0}));
    done3 = 3'b010; step();
    chk("wd_next_phase", 32'(en3), 32'(3'b100));
    done3 = 3'b100; step(); done3 = '0;
    chk("wd_frame_done", 32'({fd3, cnt3}), 32'({1'b1, 16'd1}));
    step();
    chk("wd_refire", 32'({en3, fs3}), 32'({3'b001, 1'b1}));
    done3 = 3'b001; step(); done3 = '0;
    chk("rst_pre", 32'(en3), 32'(3'b010));

    // ---- async reset mid-frame ----
    resetn = 1'b0;
    #1;
    chk("rst_async", 32'({en3, cur3, fs3, fd3, cnt3, te3, tp3, ov3}), 32'd0);
    resetn = 1'b1;
    step();
    chk("rst_resume", 32'({en3, cur3, fs3, cnt3}), 32'({3'b001, 2'd0, 1'b1, 16'd0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
